// File: rtl/rioencoder_poller.sv
// Half-duplex RS485 master sequencer: round-robin polls encoders with a one-byte 8N1 request,
// then waits for the receiver's result strobes and keeps per-node health and error counters.
module rioencoder_poller #(
  parameter int unsigned ClkFrequency  = 12000000,
  parameter int unsigned Baud          = 2000000,
  parameter int unsigned PollFrequency = 1000,
  parameter int unsigned NumNodes      = 1,
  parameter logic [7:0]  ReqCmd        = 8'h02,
  parameter int unsigned GuardBits     = 1,
  parameter int unsigned TimeoutBits   = 120,
  parameter int unsigned ErrLimit      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       rx_valid,
  input  logic       rx_crc_err,
  output logic       tx,
  output logic       rw,
  output logic [1:0] node,
  output logic       sample,
  output logic [3:0] node_ok,
  output logic [7:0] timeout_cnt,
  output logic [7:0] crc_cnt,
  output logic       overrun
);

  localparam int unsigned BitCycles   = ClkFrequency / Baud;
  localparam int unsigned PollCycles  = ClkFrequency / PollFrequency;
  localparam int unsigned GuardCycles = (GuardBits * BitCycles > 0) ? GuardBits * BitCycles : 1;
  localparam int unsigned WaitCycles  = TimeoutBits * BitCycles;
  localparam int unsigned MaxA        = (GuardCycles > BitCycles) ? GuardCycles : BitCycles;
  localparam int unsigned TmrMax      = (MaxA > WaitCycles) ? MaxA : WaitCycles;
  localparam int unsigned TmrW        = $clog2(TmrMax + 1);
  localparam int unsigned PollW       = (PollCycles > 1) ? $clog2(PollCycles) : 1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GUARD_PRE  = 3'd1,
    ST_TX         = 3'd2,
    ST_GUARD_POST = 3'd3,
    ST_WAIT       = 3'd4
  } state_t;

  state_t            state_r;
  logic [PollW-1:0]  poll_r;
  logic [TmrW-1:0]   tmr_r;
  logic [3:0]        bit_r;
  logic              tx_r;
  logic              rw_r;
  logic [1:0]        node_r;
  logic              sample_r;
  logic              adv_r;
  logic [3:0]        node_ok_r;
  logic [7:0]        tmo_cnt_r;
  logic [7:0]        crc_cnt_r;
  logic              overrun_r;
  logic [3:0]        fail_r [4];

  logic              tick_s;
  logic [9:0]        frame_s;
  logic [3:0]        next_bit_s;
  logic [3:0]        fail_cur_s;
  logic [3:0]        fail_inc_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [1:0] next_node(input logic [1:0] n);
    if (NumNodes <= 1) begin
      return 2'd0;
    end else if (n >= 2'(NumNodes - 1)) begin
      return 2'd0;
    end else begin
      return n + 2'd1;
    end
  endfunction

  assign tick_s     = enable && (poll_r == PollW'(PollCycles - 1));
  // Line order: start bit, request byte LSB first, stop bit.
  assign frame_s    = {1'b1, ReqCmd[7:2], node_r, 1'b0};
  assign next_bit_s = bit_r + 4'd1;

  // Failure count the current node would hold after one more failed poll.
  always_comb begin
    fail_cur_s = fail_r[node_r];
    if (fail_cur_s < 4'(ErrLimit)) begin
      fail_inc_s = fail_cur_s + 4'd1;
    end else begin
      fail_inc_s = fail_cur_s;
    end
  end

  // Poll tick generator: free-running while enabled, parked at zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_r <= '0;
    end else if (!enable) begin
      poll_r <= '0;
    end else if (poll_r == PollW'(PollCycles - 1)) begin
      poll_r <= '0;
    end else begin
      poll_r <= poll_r + PollW'(1);
    end
  end

  // Transaction sequencer with registered line outputs, result attribution and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      tmr_r     <= '0;
      bit_r     <= 4'd0;
      tx_r      <= 1'b1;
      rw_r      <= 1'b0;
      node_r    <= 2'd0;
      sample_r  <= 1'b0;
      adv_r     <= 1'b0;
      node_ok_r <= 4'd0;
      tmo_cnt_r <= 8'd0;
      crc_cnt_r <= 8'd0;
      overrun_r <= 1'b0;
      fail_r    <= '{default: 4'd0};
    end else begin
      sample_r <= 1'b0;
      if (tick_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
      // Node moves on only after the sample cycle so results stay attributed.
      if (adv_r) begin
        node_r <= next_node(node_r);
        adv_r  <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (tick_s) begin
            state_r <= ST_GUARD_PRE;
            rw_r    <= 1'b1;
            tmr_r   <= '0;
          end
        end
        ST_GUARD_PRE: begin
          if (tmr_r == TmrW'(GuardCycles - 1)) begin
            state_r <= ST_TX;
            tmr_r   <= '0;
            bit_r   <= 4'd0;
            tx_r    <= frame_s[0];
          end else begin
            tmr_r <= tmr_r + TmrW'(1);
          end
        end
        ST_TX: begin
          if (tmr_r == TmrW'(BitCycles - 1)) begin
            tmr_r <= '0;
            if (bit_r == 4'd9) begin
              state_r <= ST_GUARD_POST;
              tx_r    <= 1'b1;
            end else begin
              bit_r <= next_bit_s;
              tx_r  <= frame_s[next_bit_s];
            end
          end else begin
            tmr_r <= tmr_r + TmrW'(1);
          end
        end
        ST_GUARD_POST: begin
          if (tmr_r == TmrW'(GuardCycles - 1)) begin
            state_r <= ST_WAIT;
            rw_r    <= 1'b0;
            tmr_r   <= '0;
          end else begin
            tmr_r <= tmr_r + TmrW'(1);
          end
        end
        ST_WAIT: begin
          if (rx_valid) begin
            state_r           <= ST_IDLE;
            adv_r             <= 1'b1;
            sample_r          <= 1'b1;
            node_ok_r[node_r] <= 1'b1;
            fail_r[node_r]    <= 4'd0;
          end else if (rx_crc_err || (tmr_r == TmrW'(WaitCycles - 1))) begin
            state_r        <= ST_IDLE;
            adv_r          <= 1'b1;
            fail_r[node_r] <= fail_inc_s;
            if (fail_inc_s == 4'(ErrLimit)) begin
              node_ok_r[node_r] <= 1'b0;
            end
            if (rx_crc_err) begin
              crc_cnt_r <= sat_inc8(crc_cnt_r);
            end else begin
              tmo_cnt_r <= sat_inc8(tmo_cnt_r);
            end
          end else begin
            tmr_r <= tmr_r + TmrW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_r    <= 1'b1;
          rw_r    <= 1'b0;
        end
      endcase
    end
  end

  assign tx          = tx_r;
  assign rw          = rw_r;
  assign node        = node_r;
  assign sample      = sample_r;
  assign node_ok     = node_ok_r;
  assign timeout_cnt = tmo_cnt_r;
  assign crc_cnt     = crc_cnt_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_rioencoder_poller.sv
// Bench for rioencoder_poller: three nodes, short poll period, random responses checked
// against a transaction-level model of health, counters, node rotation and overrun.
module tb_rioencoder_poller;

  localparam int        NUMN   = 3;
  localparam int        POLLC  = 400;
  localparam int        RWLEN  = 72;
  localparam int        TMO    = 720;
  localparam int        ERRLIM = 3;
  localparam logic [7:0] REQ   = 8'hA6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx_valid = 1'b0;
  logic       rx_crc_err = 1'b0;
  logic       tx;
  logic       rw;
  logic [1:0] node;
  logic       sample;
  logic [3:0] node_ok;
  logic [7:0] timeout_cnt;
  logic [7:0] crc_cnt;
  logic       overrun;

  rioencoder_poller #(
    .ClkFrequency (12000000),
    .Baud         (2000000),
    .PollFrequency(30000),
    .NumNodes     (NUMN),
    .ReqCmd       (REQ),
    .GuardBits    (1),
    .TimeoutBits  (120),
    .ErrLimit     (ERRLIM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_valid   (rx_valid),
    .rx_crc_err (rx_crc_err),
    .tx         (tx),
    .rw         (rw),
    .node       (node),
    .sample     (sample),
    .node_ok    (node_ok),
    .timeout_cnt(timeout_cnt),
    .crc_cnt    (crc_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int         m_node;
  logic [3:0] m_ok;
  int         m_fail [4];
  int         m_tmo;
  int         m_crc;
  logic       m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_node = 0;
    m_ok   = 4'd0;
    for (int i = 0; i < 4; i++) m_fail[i] = 0;
    m_tmo  = 0;
    m_crc  = 0;
    m_ovr  = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx"},      32'(tx),          32'd1);
    chk({tag, "_rw"},      32'(rw),          32'd0);
    chk({tag, "_node"},    32'(node),        32'd0);
    chk({tag, "_sample"},  32'(sample),      32'd0);
    chk({tag, "_node_ok"}, 32'(node_ok),     32'd0);
    chk({tag, "_tmo"},     32'(timeout_cnt), 32'd0);
    chk({tag, "_crc"},     32'(crc_cnt),     32'd0);
    chk({tag, "_ovr"},     32'(overrun),     32'd0);
  endtask

  // kind: 0 valid, 1 crc error, 2 valid+crc same cycle, 3 no response (timeout)
  task automatic txn(input int kind, input int dly, input bit stray, input bit drop_en);
    bit          got;
    logic [80:0] txs;
    int          rwlen;
    int          exitw;
    int          quiet;
    logic [7:0]  byt;
    logic [7:0]  req;
    logic [1:0]  expn;
    logic [1:0]  nxtn;
    bit          good;
    got   = 1'b0;
    txs   = '1;
    rwlen = 0;
    quiet = 0;
    req   = REQ;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rw === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("rw_rise", 32'(got), 32'd1);
    if (!got) return;
    expn = 2'(m_node);
    chk("node_at_req", 32'(node), 32'(expn));
    while (rw === 1'b1 && rwlen < 80) begin
      rwlen++;
      txs[rwlen] = tx;
      rx_valid = stray && (rwlen == 30);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    chk("rw_len", 32'(rwlen), 32'(RWLEN));
    for (int b = 0; b < 8; b++) byt[b] = txs[16 + 6 * b];
    chk("req_byte", 32'(byt), 32'({req[7:2], expn}));
    chk("frame_bits", 32'({txs[6], txs[10], txs[64]}), 32'b101);
    exitw = (kind == 3) ? TMO : dly;
    for (int w = 1; w <= exitw; w++) begin
      if (rw !== 1'b0 || sample !== 1'b0) quiet++;
      if (drop_en && w == 10) enable = 1'b0;
      rx_valid   = (kind == 0 || kind == 2) && (w == exitw);
      rx_crc_err = (kind == 1 || kind == 2) && (w == exitw);
      @(negedge clk);
    end
    rx_valid   = 1'b0;
    rx_crc_err = 1'b0;
    chk("wait_quiet", 32'(quiet), 32'd0);
    good = (kind == 0 || kind == 2);
    if (good) begin
      m_ok[m_node]   = 1'b1;
      m_fail[m_node] = 0;
    end else begin
      if (kind == 1) m_crc = (m_crc < 255) ? m_crc + 1 : 255;
      else           m_tmo = (m_tmo < 255) ? m_tmo + 1 : 255;
      if (m_fail[m_node] < ERRLIM) m_fail[m_node]++;
      if (m_fail[m_node] >= ERRLIM) m_ok[m_node] = 1'b0;
    end
    // a later tick lands inside the transaction when it outlasts the poll period
    if (!drop_en && (RWLEN + exitw) >= POLLC) m_ovr = 1'b1;
    chk("sample_pulse", 32'(sample), 32'(good));
    chk("node_at_sample", 32'(node), 32'(expn));
    chk("node_ok", 32'(node_ok), 32'(m_ok));
    chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tmo));
    chk("crc_cnt", 32'(crc_cnt), 32'(m_crc));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    m_node = (m_node + 1) % NUMN;
    nxtn = 2'(m_node);
    @(negedge clk);
    chk("sample_end", 32'(sample), 32'd0);
    chk("node_next", 32'(node), 32'(nxtn));
    rx_crc_err = 1'b1;
    @(negedge clk);
    rx_crc_err = 1'b0;
  endtask

  initial begin
    int quiet;
    bit got;
    model_reset();
    @(negedge clk);
    chk_reset_state("reset");
    rst_n  = 1'b1;
    enable = 1'b1;

    txn(0, 50, 1'b0, 1'b0);
    txn(0, $urandom_range(20, 300), 1'b0, 1'b0);
    txn(0, $urandom_range(20, 300), 1'b0, 1'b0);
    txn(2, 40, 1'b1, 1'b0);
    txn(1, 60, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      txn($urandom_range(0, 3), $urandom_range(1, 300), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int i = 0; i < 9; i++) txn(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      txn($urandom_range(0, 2), $urandom_range(1, 300), 1'($urandom_range(0, 1)), 1'b0);
    end

    // reset in the middle of the request byte
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (rw === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("rw_rise_pre_reset", 32'(got), 32'd1);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_state("midtx_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // enable dropped while waiting: transaction finishes, then the bus stays quiet
    txn(3, 0, 1'b0, 1'b1);
    quiet = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (rw !== 1'b0) quiet++;
    end
    chk("idle_after_disable", 32'(quiet), 32'd0);
    chk("final_tmo", 32'(timeout_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
